// File: rtl/mux4_arbiter_if.sv
// Handshake/bus bundle between the four requesters and the arbiter.
// The master side drives requests, the release strobe and data; the slave
// side (the arbiter) returns the one-hot grant, select index, mux enable
// and the shared mux output.
interface mux4_arbiter_if;
    logic [3:0] req;
    logic       rel;
    logic [3:0] D;
    logic [3:0] grant;
    logic [1:0] s;
    logic       en;
    logic       y;

    modport master (output req, rel, D, input grant, s, en, y);
    modport slave  (input req, rel, D, output grant, s, en, y);
endinterface

// File: rtl/mux4_arbiter.sv
// Four-way round-robin arbiter driving a shared 4:1 mux.
// An owner keeps the mux until it releases, drops its request, or has held
// it for MAX_HOLD cycles while someone else waits. Every hand-over passes
// through a one-cycle GAP with the mux disabled (break-before-make).
module mux4_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux4_arbiter_if.slave bus
);
    localparam int            CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    grant_q;
    logic [1:0]    s_q;
    logic          en_q;
    logic [1:0]    last;
    logic [CW-1:0] count;

    logic [1:0]    win;
    logic [1:0]    idx;
    logic          found;
    logic          others;
    logic          owner_exit;

    // Round-robin pick: scan last+1 .. last+4 (wrapping), first set request wins.
    always_comb begin
        win   = last;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Exit conditions for the current owner; rel and preemption collapse into one exit.
    assign others     = |(bus.req & ~(4'b0001 << s_q));
    assign owner_exit = bus.rel | ~bus.req[s_q] | ((count == HOLD_MAX) & others);

    // Arbiter FSM with registered grant/select/enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= 4'b0000;
            s_q     <= 2'b00;
            en_q    <= 1'b0;
            count   <= '0;
            last    <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 4'b0000) begin
                        state   <= OWN;
                        grant_q <= 4'b0001 << win;
                        s_q     <= win;
                        en_q    <= 1'b1;
                        count   <= CW'(1);
                        last    <= win;
                    end
                end
                OWN: begin
                    if (owner_exit) begin
                        state   <= GAP;
                        grant_q <= 4'b0000;
                        en_q    <= 1'b0;
                    end else if (count != HOLD_MAX) begin
                        count <= count + CW'(1);
                    end
                end
                GAP: begin
                    // s_q deliberately held so the select does not glitch during the gap.
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 4'b0000;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.s     = s_q;
    assign bus.en    = en_q;
    // en is only high while a single grant bit is set, so y never leaks a non-owner.
    assign bus.y     = en_q & bus.D[s_q];
endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed scenarios with literal expectations plus
// a cycle-level ownership model compared against the DUT on every negedge.
module tb_mux4_arbiter;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mux4_arbiter_if bus();

    mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: who owns the mux, how long, whether we are in the post-release gap.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    int m_sel   = 0;
    bit m_gap   = 1'b0;
    bit started = 1'b0;

    function automatic int pick(input logic [3:0] r, input int lst);
        int w;
        w = -1;
        for (int k = 1; k <= 4; k++)
            if (w < 0 && r[(lst + k) % 4]) w = (lst + k) % 4;
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_gap   <= 1'b0;
            m_last  <= 3;
            m_sel   <= 0;
            m_held  <= 0;
            started <= 1'b1;
        end else if (m_gap) begin
            m_gap <= 1'b0;
        end else if (m_owner >= 0) begin
            if (bus.rel || !bus.req[m_owner] ||
                (m_held >= MAX_HOLD && (bus.req & ~(4'b0001 << m_owner)) != 4'b0000)) begin
                m_owner <= -1;
                m_gap   <= 1'b1;
            end else if (m_held < MAX_HOLD) begin
                m_held <= m_held + 1;
            end
        end else if (bus.req != 4'b0000) begin
            m_owner <= pick(bus.req, m_last);
            m_last  <= pick(bus.req, m_last);
            m_sel   <= pick(bus.req, m_last);
            m_held  <= 1;
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model plus structural invariants.
    always @(negedge clk) begin
        logic [3:0] eg;
        logic       ee;
        if (started) begin
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            ee = (m_owner >= 0);
            chk("model_grant", bus.grant, eg);
            chk("model_s", {2'b00, bus.s}, 4'(m_sel));
            chk("model_en", {3'b000, bus.en}, {3'b000, ee});
            chk("model_y", {3'b000, bus.y}, {3'b000, ee & bus.D[m_sel]});
            chk("onehot0", {3'b000, $onehot0(bus.grant)}, 4'b0001);
            chk("en_vs_grant", {3'b000, bus.en}, {3'b000, bus.grant != 4'b0000});
            chk("y_vs_mux", {3'b000, bus.y}, {3'b000, bus.en & bus.D[bus.s]});
        end
    end

    task automatic do_reset;
        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.rel = 1'b0;
        bus.D   = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_s", {2'b00, bus.s}, 4'd0);
        chk("rst_en", {3'b000, bus.en}, 4'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.req = 4'b0000;
        bus.rel = 1'b0;
        bus.D   = 4'b0000;

        // Full rotation with everybody requesting: 8 OWN cycles, GAP, IDLE, next.
        do_reset();
        bus.req = 4'b1111;
        bus.D   = 4'b1010;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                @(negedge clk);
                chk("rot_grant", bus.grant, 4'b0001 << (r % 4));
                chk("rot_s", {2'b00, bus.s}, 4'(r % 4));
            end
            @(negedge clk);
            chk("rot_gap", bus.grant, 4'b0000);
            chk("rot_gap_s", {2'b00, bus.s}, 4'(r % 4));
            @(negedge clk);
            chk("rot_idle", bus.grant, 4'b0000);
        end
        #1 bus.req = 4'b0000;

        // Single requester with release after 3 cycles; rel lingers into GAP/IDLE.
        do_reset();
        bus.req = 4'b0100;
        bus.D   = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rel_grant", bus.grant, 4'b0100);
            chk("rel_s", {2'b00, bus.s}, 4'd2);
            chk("rel_y", {3'b000, bus.y}, 4'd1);
        end
        #1 bus.rel = 1'b1;
        @(negedge clk);
        chk("rel_gap_grant", bus.grant, 4'b0000);
        chk("rel_gap_en", {3'b000, bus.en}, 4'd0);
        chk("rel_gap_y", {3'b000, bus.y}, 4'd0);
        chk("rel_gap_s", {2'b00, bus.s}, 4'd2);
        @(negedge clk);
        chk("rel_idle", bus.grant, 4'b0000);
        @(negedge clk);
        chk("rel_regrant", bus.grant, 4'b0100);
        #1 bus.rel = 1'b0;
        bus.D = 4'b0000;
        @(negedge clk);
        chk("rel_live_d", {3'b000, bus.y}, 4'd0);
        chk("rel_live_en", {3'b000, bus.en}, 4'd1);
        #1 bus.req = 4'b0000;

        // Lone requester keeps the grant past MAX_HOLD.
        do_reset();
        bus.req = 4'b0001;
        bus.D   = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("hold_grant", bus.grant, 4'b0001);
        end
        #1 bus.req = 4'b0000;

        // Owner 1 drops its request while 3 waits.
        do_reset();
        bus.req = 4'b0010;
        @(negedge clk);
        chk("drop_own1", bus.grant, 4'b0010);
        #1 bus.req = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        chk("drop_still1", bus.grant, 4'b0010);
        #1 bus.req = 4'b1000;
        @(negedge clk);
        chk("drop_gap", bus.grant, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        chk("drop_grant3", bus.grant, 4'b1000);
        chk("drop_s3", {2'b00, bus.s}, 4'd3);
        #1 bus.req = 4'b0000;

        // Reset mid-OWN: drop immediately, priority back to 0.
        do_reset();
        bus.req = 4'b0100;
        @(negedge clk);
        chk("rstmid_own", bus.grant, 4'b0100);
        #1 rst = 1'b1;
        bus.req = 4'b1100;
        @(negedge clk);
        chk("rstmid_grant", bus.grant, 4'b0000);
        chk("rstmid_en", {3'b000, bus.en}, 4'd0);
        chk("rstmid_s", {2'b00, bus.s}, 4'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_first", bus.grant, 4'b0100);
        #1 bus.req = 4'b0000;

        // rel coincident with preemption at count==MAX_HOLD: one GAP only.
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < MAX_HOLD; c++) begin
            @(negedge clk);
            chk("both_own0", bus.grant, 4'b0001);
            if (c == MAX_HOLD - 1) #1 bus.rel = 1'b1;
        end
        @(negedge clk);
        chk("both_gap", bus.grant, 4'b0000);
        #1 bus.rel = 1'b0;
        @(negedge clk);
        chk("both_idle", bus.grant, 4'b0000);
        @(negedge clk);
        chk("both_next", bus.grant, 4'b0010);
        #1 bus.req = 4'b0000;

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
